// File: rtl/serial_work_receive.sv
// 8N1 UART receiver that collects one WORK_BYTES getwork frame from the host
// and presents it as a single wide word to the miner core.
module serial_work_receive #(
  parameter int comm_clk_frequency = 100_000_000,
  parameter int baud_rate          = 115_200,
  parameter int WORK_BYTES         = 84,
  parameter int TIMEOUT_BITS       = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    RxD,
  output logic [8*WORK_BYTES-1:0] work_data,
  output logic                    rx_done,
  output logic                    rx_busy,
  output logic                    framing_error,
  output logic [6:0]              byte_count
);

  localparam int DIV     = comm_clk_frequency / baud_rate;
  localparam int HALF    = DIV / 2;
  localparam int FW      = 8 * WORK_BYTES;
  localparam int TIMER_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_CYC  = TIMEOUT_BITS * DIV;
  localparam int IDLE_W  = $clog2(TO_CYC + 1);

  if (DIV < 4) begin : g_div_check
    $error("serial_work_receive: comm_clk_frequency/baud_rate must be at least 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_sync_q;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          byte_q, byte_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [FW-1:0]       work_q, work_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ferr_q, ferr_d;
  logic [6:0]          count_q, count_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                timer_end;
  logic [IDLE_W-1:0]   idle_inc;

  assign timer_end = (timer_q == TIMER_W'(DIV - 1));
  assign idle_inc  = idle_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    frame_d   = frame_q;
    work_d    = work_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    ferr_d    = 1'b0;
    count_d   = count_q;
    idle_d    = '0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_sync_q) state_d = START;
      end
      START: begin
        if (timer_q == TIMER_W'(HALF - 1)) begin
          timer_d = '0;
          if (!rx_sync_q) begin
            state_d   = DATA;
            busy_d    = 1'b1;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (timer_end) begin
          timer_d   = '0;
          byte_d    = {rx_sync_q, byte_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_end) begin
          timer_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (rx_sync_q) begin
            frame_d = {frame_q[FW-9:0], byte_q};
            if (count_q == 7'(WORK_BYTES - 1)) begin
              work_d  = {frame_q[FW-9:0], byte_q};
              done_d  = 1'b1;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Partial frame is abandoned silently once the line idles too long.
    if (state_q == IDLE && count_q != 7'd0 && rx_sync_q) begin
      idle_d = idle_inc;
      if (idle_inc == IDLE_W'(TO_CYC)) begin
        count_d = '0;
        idle_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      timer_q   <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      frame_q   <= '0;
      work_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      count_q   <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      frame_q   <= frame_d;
      work_q    <= work_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
    end
  end

  assign work_data     = work_q;
  assign rx_done       = done_q;
  assign rx_busy       = busy_q;
  assign framing_error = ferr_q;
  assign byte_count    = count_q;

endmodule

// File: tb/tb_serial_work_receive.sv
// Scoreboard bench for serial_work_receive: frames are queued as they are sent,
// a monitor pops and compares on every rx_done pulse.
module tb_serial_work_receive;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 115_200;
  localparam int DIV    = 8;
  localparam int NB     = 84;
  localparam int FW     = 8 * NB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          RxD = 1'b1;
  logic [FW-1:0] work_data;
  logic          rx_done;
  logic          rx_busy;
  logic          framing_error;
  logic [6:0]    byte_count;

  serial_work_receive #(
    .comm_clk_frequency(CLK_HZ),
    .baud_rate         (BAUD),
    .WORK_BYTES        (NB),
    .TIMEOUT_BITS      (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RxD          (RxD),
    .work_data    (work_data),
    .rx_done      (rx_done),
    .rx_busy      (rx_busy),
    .framing_error(framing_error),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            fe_cnt = 0;
  bit            busy_seen = 1'b0;
  logic [FW-1:0] exp_q[$];
  logic [7:0]    fb[NB];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_busy) busy_seen = 1'b1;
      if (framing_error) begin
        fe_cnt++;
        $display("framing_error pulse %0d at byte_count %0d", fe_cnt, byte_count);
      end
      if (rx_done) begin
        logic [FW-1:0] e;
        done_cnt++;
        check("done_fe_exclusive", {{(FW-1){1'b0}}, framing_error}, '0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx_done: got pulse %0d, expected none", done_cnt);
        end else begin
          e = exp_q.pop_front();
          check("work_data", work_data, e);
          $display("frame %0d: rx_done, work_data[671:640]=%h", done_cnt, work_data[FW-1:FW-32]);
        end
      end
    end
  end

  task automatic bit_time(input logic v);
    RxD = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic fill(input int seed);
    for (int i = 0; i < NB; i++) fb[i] = 8'((i * 37 + seed * 11) ^ 8'h55);
  endtask

  function automatic logic [FW-1:0] pack_frame();
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[FW-1-8*i -: 8] = fb[i];
    return v;
  endfunction

  task automatic send_frame();
    exp_q.push_back(pack_frame());
    for (int i = 0; i < NB; i++) send_byte(fb[i], 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_work_data"}, work_data, '0);
    check({tag, "_rx_done"}, {{(FW-1){1'b0}}, rx_done}, '0);
    check({tag, "_rx_busy"}, {{(FW-1){1'b0}}, rx_busy}, '0);
    check({tag, "_framing_error"}, {{(FW-1){1'b0}}, framing_error}, '0);
    check({tag, "_byte_count"}, FW'(byte_count), '0);
  endtask

  initial begin
    logic [FW-1:0] b_vec;
    logic [7:0]    hdr[8];

    hdr = '{8'h00, 8'h00, 8'h07, 8'hff, 8'h00, 8'h00, 8'h31, 8'h8e};
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    idle(10);

    // Short low glitch must be rejected
    busy_seen = 1'b0;
    RxD = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    check("glitch_busy", FW'(busy_seen), '0);
    check("glitch_byte_count", FW'(byte_count), '0);
    check("glitch_pulses", FW'(done_cnt + fe_cnt), '0);
    $display("glitch: busy_seen=%0d byte_count=%0d", busy_seen, byte_count);

    // Clean frame
    fill(0);
    for (int i = 0; i < 8; i++) fb[i] = hdr[i];
    fb[NB-1] = 8'h00;
    send_frame();
    idle(20);
    check("clean_done_cnt", FW'(done_cnt), FW'(1));
    check("clean_word0", FW'(work_data[671:640]), FW'(32'h000007ff));
    check("clean_word1", FW'(work_data[639:608]), FW'(32'h0000318e));
    check("clean_byte_count", FW'(byte_count), '0);

    // Bad stop bit, then a good frame
    send_byte(8'h5a, 1'b0);
    idle(DIV);
    check("ferr_count", FW'(fe_cnt), FW'(1));
    check("ferr_byte_count", FW'(byte_count), '0);
    fill(1);
    b_vec = pack_frame();
    send_frame();
    idle(20);
    check("ferr_done_cnt", FW'(done_cnt), FW'(2));

    // Inter-byte timeout
    fill(2);
    for (int i = 0; i < 10; i++) send_byte(fb[i], 1'b1);
    check("to_partial_count", FW'(byte_count), FW'(10));
    idle(500);
    check("to_before_expiry", FW'(byte_count), FW'(10));
    idle(64 * 8 + 2 - 500);
    check("to_after_expiry", FW'(byte_count), '0);
    check("to_work_data_held", work_data, b_vec);
    fill(3);
    send_frame();
    idle(20);
    check("to_done_cnt", FW'(done_cnt), FW'(3));

    // Reset during bit 3 of byte 40
    fill(4);
    for (int i = 0; i < 40; i++) send_byte(fb[i], 1'b1);
    check("rst_pre_count", FW'(byte_count), FW'(40));
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(fb[40][i]);
    RxD = fb[40][3];
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(10 * DIV * 3);
    check("rst_no_spurious", FW'(done_cnt), FW'(3));
    fill(5);
    send_frame();
    idle(20);
    check("rst_done_cnt", FW'(done_cnt), FW'(4));

    // Two frames back to back
    fill(6);
    send_frame();
    fill(7);
    fb[0] = 8'hab;
    send_frame();
    idle(20);
    check("b2b_done_cnt", FW'(done_cnt), FW'(6));
    check("b2b_first_byte", FW'(work_data[671:664]), FW'(8'hab));
    check("final_fe_count", FW'(fe_cnt), FW'(1));
    check("scoreboard_empty", FW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
